bcd_timekeeper: RTL and testbench

- Parametrised timekeeping core for the VGA clock display: seconds/minutes/hours as BCD digits, 12/24-hour display mode, synchronous time load and single-step adjust pulses.
- Sits between the button_pulse instances and the digit/font renderer; replaces the inline digit counters in the top level.
- Every digit is always legal BCD within its field range: no transient out-of-range values on any cycle.

---
 rtl/vga_clock_pkg.sv | 50 +++++
 rtl/bcd_counter.sv | 72 +++++++
 rtl/bcd_timekeeper.sv | 270 +++++++++++++++++++++++++++
 tb/tb_bcd_timekeeper.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_clock_pkg.sv
// Shared widths, load_time field layout and range limits for the BCD timekeeper.
package vga_clock_pkg;

   // Display digit widths
   localparam int unsigned SEC_U_W = 4;
   localparam int unsigned SEC_D_W = 3;
   localparam int unsigned MIN_U_W = 4;
   localparam int unsigned MIN_D_W = 3;
   localparam int unsigned HRS_U_W = 4;
   localparam int unsigned HRS_D_W = 2;

   // load_time layout: {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u}
   localparam int unsigned LOAD_W    = 20;
   localparam int unsigned SEC_U_LSB = 0;
   localparam int unsigned SEC_D_LSB = 4;
   localparam int unsigned MIN_U_LSB = 7;
   localparam int unsigned MIN_D_LSB = 11;
   localparam int unsigned HRS_U_LSB = 14;
   localparam int unsigned HRS_D_LSB = 18;

   // Legal-range limits
   localparam int unsigned BCD_MAX  = 9;
   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MIN_MAX  = 59;
   localparam int unsigned HRS_MAX  = 23;
   localparam int unsigned HRS_NOON = 12;

   typedef struct packed {
      logic [HRS_D_W-1:0] hrs_d;
      logic [HRS_U_W-1:0] hrs_u;
      logic [MIN_D_W-1:0] min_d;
      logic [MIN_U_W-1:0] min_u;
      logic [SEC_D_W-1:0] sec_d;
      logic [SEC_U_W-1:0] sec_u;
   } time_bcd_t;

   // True when every digit is legal BCD and the time is within 00:00:00..23:59:59
   function automatic logic time_legal(input time_bcd_t t);
      logic units_ok;
      logic tens_ok;
      logic hrs_ok;
      units_ok = (t.sec_u <= SEC_U_W'(BCD_MAX)) && (t.min_u <= MIN_U_W'(BCD_MAX)) &&
                 (t.hrs_u <= HRS_U_W'(BCD_MAX));
      tens_ok  = (t.sec_d <= SEC_D_W'(SEC_MAX / 10)) && (t.min_d <= MIN_D_W'(MIN_MAX / 10));
      hrs_ok   = (t.hrs_d < HRS_D_W'(HRS_MAX / 10)) ||
                 ((t.hrs_d == HRS_D_W'(HRS_MAX / 10)) && (t.hrs_u <= HRS_U_W'(HRS_MAX % 10)));
      return units_ok && tens_ok && hrs_ok;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// One two-digit BCD field (tens/units) with increment, parallel load and wrap carry.
// Exposes next-state digits so the parent can register derived display values
// in the same cycle the field updates.
module bcd_counter #(
   parameter int unsigned MAX_TENS              = 5,
   parameter int unsigned MAX_UNITS_AT_MAX_TENS = 9,
   parameter int unsigned TENS_W                = 3,
   parameter int unsigned RESET_TENS            = 0,
   parameter int unsigned RESET_UNITS           = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_inc,
   input  logic              i_load,
   input  logic [TENS_W-1:0] i_load_tens,
   input  logic [3:0]        i_load_units,
   output logic [TENS_W-1:0] o_tens,
   output logic [3:0]        o_units,
   output logic [TENS_W-1:0] o_tens_nxt_c,
   output logic [3:0]        o_units_nxt_c,
   output logic              o_carry_c
);

   localparam int unsigned UNITS_W = 4;

   logic [TENS_W-1:0]  r_tens;
   logic [UNITS_W-1:0] r_units;
   logic [TENS_W-1:0]  w_tens_nxt;
   logic [UNITS_W-1:0] w_units_nxt;
   logic               w_at_max;

   assign w_at_max = (r_tens == TENS_W'(MAX_TENS)) &&
                     (r_units == UNITS_W'(MAX_UNITS_AT_MAX_TENS));

   // Next digits: load wins, otherwise increment with units->tens ripple and field wrap
   always_comb begin
      w_tens_nxt  = r_tens;
      w_units_nxt = r_units;
      if (i_load) begin
         w_tens_nxt  = i_load_tens;
         w_units_nxt = i_load_units;
      end else if (i_inc) begin
         if (w_at_max) begin
            w_tens_nxt  = '0;
            w_units_nxt = '0;
         end else if (r_units == UNITS_W'(9)) begin
            w_tens_nxt  = r_tens + TENS_W'(1);
            w_units_nxt = '0;
         end else begin
            w_units_nxt = r_units + UNITS_W'(1);
         end
      end
   end

   // Digit state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tens  <= TENS_W'(RESET_TENS);
         r_units <= UNITS_W'(RESET_UNITS);
      end else begin
         r_tens  <= w_tens_nxt;
         r_units <= w_units_nxt;
      end
   end

   assign o_tens        = r_tens;
   assign o_units       = r_units;
   assign o_tens_nxt_c  = w_tens_nxt;
   assign o_units_nxt_c = w_units_nxt;
   assign o_carry_c     = i_inc && !i_load && w_at_max;

endmodule

// File: rtl/bcd_timekeeper.sv
// BCD time-of-day core for the VGA clock: prescaled seconds tick with carry ripple,
// per-field adjust pulses, checked time load and 12/24-hour display conversion.
// Optional alarm comparator enabled by defining TIMEKEEPER_ALARM_EN.
module bcd_timekeeper
   import vga_clock_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 31_500_000,
   parameter int unsigned PRESCALE_W = $clog2(CLK_HZ),
   parameter int unsigned RESET_HRS  = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               mode_12h,
   input  logic               adj_sec,
   input  logic               adj_min,
   input  logic               adj_hrs,
   input  logic               load_valid,
   input  logic [LOAD_W-1:0]  load_time,
`ifdef TIMEKEEPER_ALARM_EN
   input  logic               alarm_set,
   input  logic               alarm_en,
   output logic               alarm,
`endif
   output logic               load_ready,
   output logic               load_err,
   output logic [SEC_U_W-1:0] sec_u,
   output logic [SEC_D_W-1:0] sec_d,
   output logic [MIN_U_W-1:0] min_u,
   output logic [MIN_D_W-1:0] min_d,
   output logic [HRS_U_W-1:0] hrs_u,
   output logic [HRS_D_W-1:0] hrs_d,
   output logic               pm,
   output logic               sec_tick,
   output logic               min_wrap
);

   localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(CLK_HZ - 1);
   localparam int unsigned RST_HRS_D = RESET_HRS / 10;
   localparam int unsigned RST_HRS_U = RESET_HRS % 10;
   localparam int unsigned HBIN_W    = 5;

   logic [PRESCALE_W-1:0] r_presc;
   logic [PRESCALE_W-1:0] w_presc_nxt;
   logic                  r_pending;
   logic                  w_pending_nxt;
   logic                  r_load_ready;
   logic                  r_load_err;
   logic                  r_sec_tick;
   logic                  r_min_wrap;
   logic [HRS_U_W-1:0]    r_hrs_u;
   logic [HRS_D_W-1:0]    r_hrs_d;
   logic                  r_pm;

   logic w_tick;
   logic w_adj_any;
   logic w_legal;
   logic w_load_en;
   logic w_do_tick;
   logic w_sec_inc;
   logic w_min_inc;
   logic w_hrs_inc;
   logic w_sec_carry;
   logic w_min_carry;
   logic w_hrs_carry;
   logic w_sec_chg;
   logic w_min_chg;

   logic [SEC_U_W-1:0] w_sec_u, w_sec_u_nxt;
   logic [SEC_D_W-1:0] w_sec_d, w_sec_d_nxt;
   logic [MIN_U_W-1:0] w_min_u, w_min_u_nxt;
   logic [MIN_D_W-1:0] w_min_d, w_min_d_nxt;
   logic [HRS_U_W-1:0] w_hrs_u, w_hrs_u_nxt;
   logic [HRS_D_W-1:0] w_hrs_d, w_hrs_d_nxt;

   logic [HBIN_W-1:0]  w_hrs_bin;
   logic [HBIN_W-1:0]  w_disp_bin;
   logic [HRS_D_W-1:0] w_disp_d;
   logic [HRS_U_W-1:0] w_disp_u;
   logic               w_pm;

   assign w_tick    = (r_presc == PRESC_MAX);
   assign w_adj_any = adj_sec || adj_min || adj_hrs;
   assign w_legal   = time_legal(time_bcd_t'(load_time));
   assign w_load_en = load_valid && w_legal;

   // Load beats adjust beats tick; a deferred tick is replayed on the next free cycle
   assign w_do_tick = !load_valid && !w_adj_any && (w_tick || r_pending);
   assign w_sec_inc = !load_valid && (adj_sec || w_do_tick);
   assign w_min_inc = !load_valid && (adj_min || (w_do_tick && w_sec_carry));
   assign w_hrs_inc = !load_valid && (adj_hrs || (w_do_tick && w_min_carry));

   bcd_counter #(
      .MAX_TENS              (SEC_MAX / 10),
      .MAX_UNITS_AT_MAX_TENS (SEC_MAX % 10),
      .TENS_W                (SEC_D_W),
      .RESET_TENS            (0),
      .RESET_UNITS           (0)
   ) u_sec (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_inc         (w_sec_inc),
      .i_load        (w_load_en),
      .i_load_tens   (load_time[SEC_D_LSB +: SEC_D_W]),
      .i_load_units  (load_time[SEC_U_LSB +: SEC_U_W]),
      .o_tens        (w_sec_d),
      .o_units       (w_sec_u),
      .o_tens_nxt_c  (w_sec_d_nxt),
      .o_units_nxt_c (w_sec_u_nxt),
      .o_carry_c     (w_sec_carry)
   );

   bcd_counter #(
      .MAX_TENS              (MIN_MAX / 10),
      .MAX_UNITS_AT_MAX_TENS (MIN_MAX % 10),
      .TENS_W                (MIN_D_W),
      .RESET_TENS            (0),
      .RESET_UNITS           (0)
   ) u_min (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_inc         (w_min_inc),
      .i_load        (w_load_en),
      .i_load_tens   (load_time[MIN_D_LSB +: MIN_D_W]),
      .i_load_units  (load_time[MIN_U_LSB +: MIN_U_W]),
      .o_tens        (w_min_d),
      .o_units       (w_min_u),
      .o_tens_nxt_c  (w_min_d_nxt),
      .o_units_nxt_c (w_min_u_nxt),
      .o_carry_c     (w_min_carry)
   );

   bcd_counter #(
      .MAX_TENS              (HRS_MAX / 10),
      .MAX_UNITS_AT_MAX_TENS (HRS_MAX % 10),
      .TENS_W                (HRS_D_W),
      .RESET_TENS            (RST_HRS_D),
      .RESET_UNITS           (RST_HRS_U)
   ) u_hrs (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_inc         (w_hrs_inc),
      .i_load        (w_load_en),
      .i_load_tens   (load_time[HRS_D_LSB +: HRS_D_W]),
      .i_load_units  (load_time[HRS_U_LSB +: HRS_U_W]),
      .o_tens        (w_hrs_d),
      .o_units       (w_hrs_u),
      .o_tens_nxt_c  (w_hrs_d_nxt),
      .o_units_nxt_c (w_hrs_u_nxt),
      .o_carry_c     (w_hrs_carry)
   );

   assign w_sec_chg = {w_sec_d_nxt, w_sec_u_nxt} != {w_sec_d, w_sec_u};
   assign w_min_chg = {w_min_d_nxt, w_min_u_nxt} != {w_min_d, w_min_u};

   // Prescaler restart and pending-tick bookkeeping
   always_comb begin
      w_presc_nxt   = w_tick ? '0 : r_presc + PRESCALE_W'(1);
      w_pending_nxt = r_pending;
      if (w_load_en || (!load_valid && adj_sec)) begin
         w_presc_nxt = '0;
      end
      if (load_valid) begin
         w_pending_nxt = 1'b0;
      end else if (w_adj_any) begin
         w_pending_nxt = r_pending || w_tick;
      end else begin
         w_pending_nxt = r_pending && w_tick;
      end
   end

   // Hour display: 24-hour value or 12-hour conversion of the next internal hour
   always_comb begin
      w_hrs_bin  = HBIN_W'(w_hrs_d_nxt) * HBIN_W'(10) + HBIN_W'(w_hrs_u_nxt);
      w_pm       = (w_hrs_bin >= HBIN_W'(HRS_NOON));
      w_disp_bin = w_hrs_bin;
      if (mode_12h) begin
         if (w_hrs_bin == '0) begin
            w_disp_bin = HBIN_W'(HRS_NOON);
         end else if (w_hrs_bin > HBIN_W'(HRS_NOON)) begin
            w_disp_bin = w_hrs_bin - HBIN_W'(HRS_NOON);
         end
      end
      w_disp_d = '0;
      if (w_disp_bin >= HBIN_W'(20)) begin
         w_disp_d = HRS_D_W'(2);
      end else if (w_disp_bin >= HBIN_W'(10)) begin
         w_disp_d = HRS_D_W'(1);
      end
      w_disp_u = HRS_U_W'(w_disp_bin - HBIN_W'(w_disp_d) * HBIN_W'(10));
   end

   // Prescaler, pending flag and registered status/display outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc      <= '0;
         r_pending    <= 1'b0;
         r_load_ready <= 1'b0;
         r_load_err   <= 1'b0;
         r_sec_tick   <= 1'b0;
         r_min_wrap   <= 1'b0;
         r_hrs_u      <= HRS_U_W'(RST_HRS_U);
         r_hrs_d      <= HRS_D_W'(RST_HRS_D);
         r_pm         <= (RESET_HRS >= HRS_NOON);
      end else begin
         r_presc      <= w_presc_nxt;
         r_pending    <= w_pending_nxt;
         r_load_ready <= 1'b1;
         r_load_err   <= load_valid && !w_legal;
         r_sec_tick   <= w_sec_chg;
         r_min_wrap   <= w_min_chg;
         r_hrs_u      <= w_disp_u;
         r_hrs_d      <= w_disp_d;
         r_pm         <= w_pm;
      end
   end

`ifdef TIMEKEEPER_ALARM_EN
   logic [HRS_D_W-1:0] r_alm_hrs_d;
   logic [HRS_U_W-1:0] r_alm_hrs_u;
   logic [MIN_D_W-1:0] r_alm_min_d;
   logic [MIN_U_W-1:0] r_alm_min_u;
   logic               r_alarm;
   logic               w_hrs_chg;
   logic               w_alarm_hit;

   assign w_hrs_chg   = {w_hrs_d_nxt, w_hrs_u_nxt} != {w_hrs_d, w_hrs_u};
   assign w_alarm_hit = (w_sec_chg || w_min_chg || w_hrs_chg) &&
                        ({w_hrs_d_nxt, w_hrs_u_nxt} == {r_alm_hrs_d, r_alm_hrs_u}) &&
                        ({w_min_d_nxt, w_min_u_nxt} == {r_alm_min_d, r_alm_min_u}) &&
                        ({w_sec_d_nxt, w_sec_u_nxt} == '0);

   // Alarm time capture and latched alarm flag (cleared by disable or any adjust)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_alm_hrs_d <= '0;
         r_alm_hrs_u <= '0;
         r_alm_min_d <= '0;
         r_alm_min_u <= '0;
         r_alarm     <= 1'b0;
      end else begin
         if (alarm_set) begin
            r_alm_hrs_d <= load_time[HRS_D_LSB +: HRS_D_W];
            r_alm_hrs_u <= load_time[HRS_U_LSB +: HRS_U_W];
            r_alm_min_d <= load_time[MIN_D_LSB +: MIN_D_W];
            r_alm_min_u <= load_time[MIN_U_LSB +: MIN_U_W];
         end
         if (!alarm_en || w_adj_any) begin
            r_alarm <= 1'b0;
         end else if (w_alarm_hit) begin
            r_alarm <= 1'b1;
         end
      end
   end

   assign alarm = r_alarm;
`endif

   assign load_ready = r_load_ready;
   assign load_err   = r_load_err;
   assign sec_u      = w_sec_u;
   assign sec_d      = w_sec_d;
   assign min_u      = w_min_u;
   assign min_d      = w_min_d;
   assign hrs_u      = r_hrs_u;
   assign hrs_d      = r_hrs_d;
   assign pm         = r_pm;
   assign sec_tick   = r_sec_tick;
   assign min_wrap   = r_min_wrap;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench for bcd_timekeeper: directed scenarios then random traffic,
// compared each cycle against a seconds-of-day reference model.
module tb_bcd_timekeeper;

   localparam int unsigned CLK_HZ    = 4;
   localparam int unsigned RESET_HRS = 0;
   localparam int          DAY_S     = 86400;

   logic        clk;
   logic        reset_n;
   logic        mode_12h;
   logic        adj_sec, adj_min, adj_hrs;
   logic        load_valid;
   logic [19:0] load_time;
   logic        load_ready, load_err;
   logic [3:0]  sec_u, min_u, hrs_u;
   logic [2:0]  sec_d, min_d;
   logic [1:0]  hrs_d;
   logic        pm, sec_tick, min_wrap;
`ifdef TIMEKEEPER_ALARM_EN
   logic        alarm_set, alarm_en, alarm;
   assign alarm_set = 1'b0;
   assign alarm_en  = 1'b0;
`endif

   bcd_timekeeper #(
      .CLK_HZ    (CLK_HZ),
      .RESET_HRS (RESET_HRS)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mode_12h   (mode_12h),
      .adj_sec    (adj_sec),
      .adj_min    (adj_min),
      .adj_hrs    (adj_hrs),
      .load_valid (load_valid),
      .load_time  (load_time),
`ifdef TIMEKEEPER_ALARM_EN
      .alarm_set  (alarm_set),
      .alarm_en   (alarm_en),
      .alarm      (alarm),
`endif
      .load_ready (load_ready),
      .load_err   (load_err),
      .sec_u      (sec_u),
      .sec_d      (sec_d),
      .min_u      (min_u),
      .min_d      (min_d),
      .hrs_u      (hrs_u),
      .hrs_d      (hrs_d),
      .pm         (pm),
      .sec_tick   (sec_tick),
      .min_wrap   (min_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: time of day in seconds, prescaler count, pending flag
   int m_tod;
   int m_cnt;
   bit m_pend;
   bit m_err;
   bit m_sec_chg;
   bit m_min_chg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [19:0] pack(input int h, input int m, input int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [19:0] dut_time();
      return {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u};
   endfunction

   task automatic model_reset();
      m_tod     = RESET_HRS * 3600;
      m_cnt     = 0;
      m_pend    = 1'b0;
      m_err     = 1'b0;
      m_sec_chg = 1'b0;
      m_min_chg = 1'b0;
   endtask

   task automatic model_step(input bit as, input bit am, input bit ah, input bit lv,
                             input logic [19:0] lt);
      int  h0, mi0, s0, h, mi, s;
      int  hd, hu, md, mu, sd, su;
      bit  tick;
      h0   = m_tod / 3600;
      mi0  = (m_tod / 60) % 60;
      s0   = m_tod % 60;
      tick = (m_cnt == CLK_HZ - 1);
      m_err = 1'b0;
      if (lv) begin
         hd = int'(lt[19:18]); hu = int'(lt[17:14]); md = int'(lt[13:11]);
         mu = int'(lt[10:7]);  sd = int'(lt[6:4]);   su = int'(lt[3:0]);
         if (hu <= 9 && mu <= 9 && su <= 9 && md <= 5 && sd <= 5 && (hd * 10 + hu) <= 23) begin
            m_tod = (hd * 10 + hu) * 3600 + (md * 10 + mu) * 60 + (sd * 10 + su);
            m_cnt = 0;
         end else begin
            m_err = 1'b1;
            m_cnt = (m_cnt + 1) % CLK_HZ;
         end
         m_pend = 1'b0;
      end else if (as || am || ah) begin
         h  = ah ? (h0 + 1) % 24 : h0;
         mi = am ? (mi0 + 1) % 60 : mi0;
         s  = as ? (s0 + 1) % 60 : s0;
         m_tod  = h * 3600 + mi * 60 + s;
         m_cnt  = as ? 0 : (m_cnt + 1) % CLK_HZ;
         m_pend = m_pend || tick;
      end else begin
         if (tick || m_pend) m_tod = (m_tod + 1) % DAY_S;
         m_pend = tick && m_pend;
         m_cnt  = (m_cnt + 1) % CLK_HZ;
      end
      m_sec_chg = (m_tod % 60) != s0;
      m_min_chg = ((m_tod / 60) % 60) != mi0;
   endtask

   // Drive one cycle of inputs, advance model, sample just after the edge and compare
   task automatic step(input bit as, input bit am, input bit ah, input bit lv,
                       input logic [19:0] lt, input bit md12);
      int h, dh;
      adj_sec = as; adj_min = am; adj_hrs = ah;
      load_valid = lv; load_time = lt; mode_12h = md12;
      model_step(as, am, ah, lv, lt);
      @(posedge clk);
      #1;
      h  = m_tod / 3600;
      dh = !md12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
      chk("time",       32'(dut_time()), 32'(pack(dh, (m_tod / 60) % 60, m_tod % 60)));
      chk("pm",         32'(pm),         32'(h >= 12));
      chk("sec_tick",   32'(sec_tick),   32'(m_sec_chg));
      chk("min_wrap",   32'(min_wrap),   32'(m_min_chg));
      chk("load_err",   32'(load_err),   32'(m_err));
      chk("load_ready", 32'(load_ready), 32'(1));
      adj_sec = 1'b0; adj_min = 1'b0; adj_hrs = 1'b0; load_valid = 1'b0;
   endtask

   task automatic idle(input int n, input bit md12);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, md12);
   endtask

   task automatic do_load(input logic [19:0] lt, input bit md12);
      step(1'b0, 1'b0, 1'b0, 1'b1, lt, md12);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_time"},  32'(dut_time()), 32'(pack(RESET_HRS, 0, 0)));
      chk({tag, "_pulse"}, 32'({sec_tick, min_wrap, load_err}), 32'(0));
      chk({tag, "_ready"}, 32'(load_ready), 32'(0));
   endtask

   int sweep_h [5] = '{0, 1, 12, 13, 23};
   int sweep_d [5] = '{12, 1, 12, 1, 11};
   int sweep_pm[5] = '{0, 0, 1, 1, 1};

   initial begin
      int wraps;
      bit rmode;
      reset_n = 1'b0; mode_12h = 1'b0;
      adj_sec = 1'b0; adj_min = 1'b0; adj_hrs = 1'b0;
      load_valid = 1'b0; load_time = '0;
      #12;
      chk_reset_outputs("reset");
      #10 reset_n = 1'b1;
      model_reset();

      // First tick arrives CLK_HZ cycles after release
      idle(CLK_HZ - 1, 1'b0);
      chk("first_tick_early", 32'(sec_u), 32'(0));
      idle(1, 1'b0);
      chk("first_tick", 32'(sec_u), 32'(1));

      // 23:59:58 through midnight
      do_load(pack(23, 59, 58), 1'b0);
      chk("load_pm", 32'(pm), 32'(1));
      wraps = 0;
      for (int i = 0; i < 12; i++) begin
         idle(1, 1'b0);
         if (min_wrap) wraps++;
         if (i == 7) chk("midnight", 32'(dut_time()), 32'(pack(0, 0, 0)));
      end
      chk("min_wrap_once", 32'(wraps), 32'(1));
      chk("midnight_pm", 32'(pm), 32'(0));

      // Minute adjust wraps without carrying into hours
      do_load(pack(10, 59, 30), 1'b0);
      idle(1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
      chk("adj_min_wrap", 32'(dut_time()), 32'(pack(10, 0, 30)));
      chk("adj_min_pulse", 32'(min_wrap), 32'(1));
      idle(6, 1'b0);

      // Seconds adjust on the exact tick cycle: pending tick follows
      do_load(pack(0, 0, 10), 1'b0);
      idle(CLK_HZ - 1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0);
      chk("adj_sec_tick", 32'(sec_u), 32'(1));
      idle(1, 1'b0);
      chk("pending_tick", 32'(sec_u), 32'(2));
      idle(CLK_HZ, 1'b0);

      // 12-hour display sweep
      for (int i = 0; i < 5; i++) begin
         do_load(pack(sweep_h[i], 0, 0), 1'b1);
         chk("sweep_hrs", 32'({hrs_d, hrs_u}), 32'({2'(sweep_d[i] / 10), 4'(sweep_d[i] % 10)}));
         chk("sweep_pm", 32'(pm), 32'(sweep_pm[i]));
      end
      idle(2, 1'b0);

      // Illegal loads rejected, then a legal one
      do_load({2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0}, 1'b0);
      chk("err_24h", 32'(load_err), 32'(1));
      do_load({2'd1, 4'd2, 3'd6, 4'd0, 3'd0, 4'd0}, 1'b0);
      chk("err_60m", 32'(load_err), 32'(1));
      do_load(pack(7, 15, 42), 1'b0);
      chk("load_071542", 32'(dut_time()), 32'(20'b00_0111_001_0101_100_0010));
      chk("load_ok", 32'(load_err), 32'(0));

      // Asynchronous reset mid-count
      do_load(pack(5, 5, 5), 1'b0);
      idle(2, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
      idle(CLK_HZ - 1, 1'b0);
      chk("post_reset_wait", 32'(sec_u), 32'(0));
      idle(1, 1'b0);
      chk("post_reset_tick", 32'(sec_u), 32'(1));

      // Random traffic
      rmode = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit as, am, ah, lv;
         logic [19:0] lt;
         as = ($urandom_range(0, 99) < 6);
         am = ($urandom_range(0, 99) < 6);
         ah = ($urandom_range(0, 99) < 6);
         lv = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 1) == 0)
            lt = pack(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                      int'($urandom_range(50, 59)));
         else
            lt = 20'($urandom);
         if ($urandom_range(0, 99) < 8) rmode = ~rmode;
         step(as, am, ah, lv, lt, rmode);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
